// File: rtl/mem_init_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_init_loader
// Description : Parses a 32-bit valid/ready word stream of segment headers and
//               data words, and drives the instruction memory, register file
//               and system memory initialization write ports while framing the
//               whole load with Memory_Initialization.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_init_loader #(
   parameter int IM_DEPTH = 64,
   parameter int RF_DEPTH = 32,
   parameter int SM_DEPTH = 32,
   localparam int c_IM_AW = $clog2(IM_DEPTH * 4),
   localparam int c_RF_AW = $clog2(RF_DEPTH * 4),
   localparam int c_SM_AW = $clog2(SM_DEPTH * 4)
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [31:0]        in_data,
   output logic               in_ready,
   output logic [c_IM_AW-1:0] writeAddr_IM,
   output logic [31:0]        writeData_IM,
   output logic               writeEn_IM,
   output logic [c_RF_AW-1:0] writeAddr_RF_TB,
   output logic [31:0]        writeData_RF_TB,
   output logic               writeEn_RF_TB,
   output logic [c_SM_AW-1:0] writeAddr_SM_TB,
   output logic [31:0]        writeData_SM_TB,
   output logic               writeEn_SM_TB,
   output logic               Memory_Initialization,
   output logic               busy,
   output logic               done,
   output logic               error
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   localparam logic [1:0] c_TGT_IM  = 2'b00;
   localparam logic [1:0] c_TGT_RF  = 2'b01;
   localparam logic [1:0] c_TGT_SM  = 2'b10;
   localparam logic [1:0] c_TGT_END = 2'b11;

   state_t       r_state;
   state_t       w_next;

   logic [1:0]   r_tgt;      // target of the segment currently in DATA
   logic [16:0]  r_idx;      // word index of the next data word
   logic [15:0]  r_left;     // data words still to be consumed
   logic         r_discard;  // segment failed its range check
   logic         r_error;

   logic [c_IM_AW-1:0] r_waddr_im;
   logic [31:0]        r_wdata_im;
   logic               r_wen_im;
   logic [c_RF_AW-1:0] r_waddr_rf;
   logic [31:0]        r_wdata_rf;
   logic               r_wen_rf;
   logic [c_SM_AW-1:0] r_waddr_sm;
   logic [31:0]        r_wdata_sm;
   logic               r_wen_sm;

   // Header field decode
   logic [1:0]   w_hdr_tgt;
   logic [13:0]  w_hdr_s;
   logic [15:0]  w_hdr_n;
   logic         w_hdr_end;
   logic [16:0]  w_seg_top;
   logic [16:0]  w_depth;
   logic         w_range_err;

   assign w_hdr_tgt = in_data[31:30];
   assign w_hdr_s   = in_data[29:16];
   assign w_hdr_n   = in_data[15:0];
   assign w_hdr_end = (w_hdr_tgt == c_TGT_END);
   // 17-bit sum so S+N cannot wrap before the depth comparison
   assign w_seg_top = {3'b000, w_hdr_s} + {1'b0, w_hdr_n};

   // Select the depth of the target named in the incoming header
   always_comb begin
      w_depth = 17'(IM_DEPTH);
      case (w_hdr_tgt)
         c_TGT_RF: w_depth = 17'(RF_DEPTH);
         c_TGT_SM: w_depth = 17'(SM_DEPTH);
         default:  w_depth = 17'(IM_DEPTH);
      endcase
   end

   assign w_range_err = (w_seg_top > w_depth);

   // State register
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and status outputs
   always_comb begin
      w_next                = r_state;
      in_ready              = 1'b0;
      Memory_Initialization = 1'b0;
      busy                  = 1'b0;
      done                  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_HDR;
            end
         end
         S_HDR: begin
            in_ready              = 1'b1;
            Memory_Initialization = 1'b1;
            busy                  = 1'b1;
            if (in_valid) begin
               if (w_hdr_end) begin
                  w_next = S_FIN;
               end else if (w_hdr_n != 16'd0) begin
                  w_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            in_ready              = 1'b1;
            Memory_Initialization = 1'b1;
            busy                  = 1'b1;
            if (in_valid && (r_left == 16'd1)) begin
               w_next = S_HDR;
            end
         end
         S_FIN: begin
            Memory_Initialization = 1'b1;
            busy                  = 1'b1;
            done                  = 1'b1;
            w_next                = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Segment bookkeeping, error flag and registered single-cycle write strobes
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_tgt      <= 2'b00;
         r_idx      <= 17'd0;
         r_left     <= 16'd0;
         r_discard  <= 1'b0;
         r_error    <= 1'b0;
         r_waddr_im <= '0;
         r_wdata_im <= 32'd0;
         r_wen_im   <= 1'b0;
         r_waddr_rf <= '0;
         r_wdata_rf <= 32'd0;
         r_wen_rf   <= 1'b0;
         r_waddr_sm <= '0;
         r_wdata_sm <= 32'd0;
         r_wen_sm   <= 1'b0;
      end else begin
         // Ports idle at zero unless a word is written this cycle
         r_waddr_im <= '0;
         r_wdata_im <= 32'd0;
         r_wen_im   <= 1'b0;
         r_waddr_rf <= '0;
         r_wdata_rf <= 32'd0;
         r_wen_rf   <= 1'b0;
         r_waddr_sm <= '0;
         r_wdata_sm <= 32'd0;
         r_wen_sm   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_error <= 1'b0;
               end
            end
            S_HDR: begin
               if (in_valid && !w_hdr_end) begin
                  r_tgt     <= w_hdr_tgt;
                  r_idx     <= {3'b000, w_hdr_s};
                  r_left    <= w_hdr_n;
                  r_discard <= w_range_err;
                  if (w_range_err) begin
                     r_error <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (in_valid) begin
                  r_idx  <= r_idx + 17'd1;
                  r_left <= r_left - 16'd1;
                  if (!r_discard) begin
                     case (r_tgt)
                        c_TGT_IM: begin
                           r_waddr_im <= {r_idx[c_IM_AW-3:0], 2'b00};
                           r_wdata_im <= in_data;
                           r_wen_im   <= 1'b1;
                        end
                        c_TGT_RF: begin
                           r_waddr_rf <= {r_idx[c_RF_AW-3:0], 2'b00};
                           r_wdata_rf <= in_data;
                           r_wen_rf   <= 1'b1;
                        end
                        c_TGT_SM: begin
                           r_waddr_sm <= {r_idx[c_SM_AW-3:0], 2'b00};
                           r_wdata_sm <= in_data;
                           r_wen_sm   <= 1'b1;
                        end
                        default: begin
                        end
                     endcase
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign writeAddr_IM    = r_waddr_im;
   assign writeData_IM    = r_wdata_im;
   assign writeEn_IM      = r_wen_im;
   assign writeAddr_RF_TB = r_waddr_rf;
   assign writeData_RF_TB = r_wdata_rf;
   assign writeEn_RF_TB   = r_wen_rf;
   assign writeAddr_SM_TB = r_waddr_sm;
   assign writeData_SM_TB = r_wdata_sm;
   assign writeEn_SM_TB   = r_wen_sm;
   assign error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_init_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_init_loader
// Description : Directed scoreboard bench for mem_init_loader. Stimulus pushes
//               expected writes into a queue; a monitor pops and compares on
//               every write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_init_loader;

   logic        clk_100MHz;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [7:0]  writeAddr_IM;
   logic [31:0] writeData_IM;
   logic        writeEn_IM;
   logic [6:0]  writeAddr_RF_TB;
   logic [31:0] writeData_RF_TB;
   logic        writeEn_RF_TB;
   logic [6:0]  writeAddr_SM_TB;
   logic [31:0] writeData_SM_TB;
   logic        writeEn_SM_TB;
   logic        Memory_Initialization;
   logic        busy;
   logic        done;
   logic        error;

   mem_init_loader #(
      .IM_DEPTH(64),
      .RF_DEPTH(32),
      .SM_DEPTH(32)
   ) u_dut (
      .clk_100MHz           (clk_100MHz),
      .reset                (reset),
      .start                (start),
      .in_valid             (in_valid),
      .in_data              (in_data),
      .in_ready             (in_ready),
      .writeAddr_IM         (writeAddr_IM),
      .writeData_IM         (writeData_IM),
      .writeEn_IM           (writeEn_IM),
      .writeAddr_RF_TB      (writeAddr_RF_TB),
      .writeData_RF_TB      (writeData_RF_TB),
      .writeEn_RF_TB        (writeEn_RF_TB),
      .writeAddr_SM_TB      (writeAddr_SM_TB),
      .writeData_SM_TB      (writeData_SM_TB),
      .writeEn_SM_TB        (writeEn_SM_TB),
      .Memory_Initialization(Memory_Initialization),
      .busy                 (busy),
      .done                 (done),
      .error                (error)
   );

   typedef struct packed {
      logic [1:0]  tgt;
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t q_exp[$];
   int  checks   = 0;
   int  failures = 0;
   int  n_done   = 0;
   int  cyc      = 0;

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   // Cycle counter used to prove back-to-back acceptance
   always @(posedge clk_100MHz) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic wr_t mk(input logic [1:0] t, input logic [7:0] a, input logic [31:0] d);
      wr_t w;
      w.tgt  = t;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   // Monitor: pop expected write on every strobe; also track done pulses
   always @(negedge clk_100MHz) begin
      int  n_en;
      wr_t got;
      if (done) n_done++;
      n_en = int'(writeEn_IM) + int'(writeEn_RF_TB) + int'(writeEn_SM_TB);
      if (n_en > 1) begin
         chk("single_strobe", 32'(n_en), 32'd1);
      end else if (n_en == 1) begin
         if (writeEn_IM)         got = mk(2'b00, writeAddr_IM, writeData_IM);
         else if (writeEn_RF_TB) got = mk(2'b01, {1'b0, writeAddr_RF_TB}, writeData_RF_TB);
         else                    got = mk(2'b10, {1'b0, writeAddr_SM_TB}, writeData_SM_TB);
         if (q_exp.size() == 0) begin
            chk("unexpected_write", {22'd0, got.tgt, got.addr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = q_exp.pop_front();
            chk("write_tgt_addr", {22'd0, got.tgt, got.addr}, {22'd0, e.tgt, e.addr});
            chk("write_data", got.data, e.data);
         end
         chk("idle_ports_zero",
             32'((writeEn_IM ? 0 : (|writeAddr_IM | |writeData_IM)) +
                 (writeEn_RF_TB ? 0 : (|writeAddr_RF_TB | |writeData_RF_TB)) +
                 (writeEn_SM_TB ? 0 : (|writeAddr_SM_TB | |writeData_SM_TB))), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_meminit", 32'(Memory_Initialization), 32'd1);
      chk("start_ready", 32'(in_ready), 32'd1);
   endtask

   // Offer one word and wait (bounded) until it is accepted; in_valid stays high
   task automatic send(input logic [31:0] w);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            tick();
            acc = 1'b1;
            break;
         end
         tick();
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_end();
      send(32'hC000_0000);
      in_valid = 1'b0;
      chk("fin_done", 32'(done), 32'd1);
      chk("fin_meminit", 32'(Memory_Initialization), 32'd1);
      chk("fin_ready", 32'(in_ready), 32'd0);
      tick();
      chk("idle_meminit", 32'(Memory_Initialization), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {writeEn_IM, writeEn_RF_TB, writeEn_SM_TB, in_ready,
                 Memory_Initialization, busy, done, error,
                 8'(writeAddr_IM | writeAddr_RF_TB | writeAddr_SM_TB),
                 16'(writeData_IM | writeData_RF_TB | writeData_SM_TB)}, 32'd0);
   endtask

   initial begin
      int c0;
      int d0;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'd0;
      repeat (3) tick();
      chk_all_zero("reset_state");
      reset = 1'b0;
      tick();

      // Load IM with three words
      do_start();
      send(32'h0000_0003);
      q_exp.push_back(mk(2'b00, 8'h00, 32'h0050_0093)); send(32'h0050_0093);
      q_exp.push_back(mk(2'b00, 8'h04, 32'h00A0_0113)); send(32'h00A0_0113);
      q_exp.push_back(mk(2'b00, 8'h08, 32'h0020_81B3)); send(32'h0020_81B3);
      send_end();
      chk("done_count_1", 32'(n_done), 32'd1);
      tick();

      // Multi-target back-to-back, no bubbles
      do_start();
      send(32'h0000_0002);
      c0 = cyc;
      q_exp.push_back(mk(2'b00, 8'h00, 32'hA5A5_0001)); send(32'hA5A5_0001);
      q_exp.push_back(mk(2'b00, 8'h04, 32'hA5A5_0002)); send(32'hA5A5_0002);
      send(32'h4005_0001);
      q_exp.push_back(mk(2'b01, 8'h14, 32'hDEAD_BEEF)); send(32'hDEAD_BEEF);
      send(32'h8000_0001);
      q_exp.push_back(mk(2'b10, 8'h00, 32'h1234_5678)); send(32'h1234_5678);
      chk("no_bubble_cycles", 32'(cyc - c0), 32'd6);
      send_end();
      tick();

      // Range error: RF S=31 N=2 discarded, following SM segment intact
      do_start();
      chk("error_clear_idle", 32'(error), 32'd0);
      send(32'h401F_0002);
      chk("error_set", 32'(error), 32'd1);
      send(32'h1111_1111);
      send(32'h2222_2222);
      send(32'h8002_0001);
      q_exp.push_back(mk(2'b10, 8'h08, 32'hCAFE_F00D)); send(32'hCAFE_F00D);
      send_end();
      chk("error_sticky", 32'(error), 32'd1);
      tick();

      // Stall: valid 1,0,0,1 within IM segment, error cleared by start
      do_start();
      chk("error_cleared_by_start", 32'(error), 32'd0);
      send(32'h0000_0002);
      q_exp.push_back(mk(2'b00, 8'h00, 32'h0BAD_0001)); send(32'h0BAD_0001);
      in_valid = 1'b0;
      tick();
      tick();
      q_exp.push_back(mk(2'b00, 8'h04, 32'h0BAD_0002)); send(32'h0BAD_0002);
      send_end();
      tick();

      // Zero-count header and start while busy
      do_start();
      send(32'h0000_0000);
      in_valid = 1'b0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_start_ignored", {30'd0, busy, in_ready}, 32'd3);
      send_end();
      chk("done_count_5", 32'(n_done), 32'd5);
      tick();

      // Reset mid-DATA after first of three words
      do_start();
      send(32'h0000_0003);
      q_exp.push_back(mk(2'b00, 8'h00, 32'h3333_3333)); send(32'h3333_3333);
      in_valid = 1'b0;
      reset    = 1'b1;
      d0       = n_done;
      tick();
      reset = 1'b0;
      chk_all_zero("mid_reset_outputs");
      tick();
      tick();
      chk("mid_reset_no_done", 32'(n_done), 32'(d0));

      // Fresh session loads normally
      do_start();
      send(32'h0002_0001);
      q_exp.push_back(mk(2'b00, 8'h08, 32'h4444_4444)); send(32'h4444_4444);
      send_end();
      tick();
      chk("done_count_total", 32'(n_done), 32'd6);
      chk("queue_drained", 32'(q_exp.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_init_loader.md
# mem_init_loader

Front-end controller that sequences the processor's memory-initialization ports (instruction memory, register file, system memory) from a single 32-bit valid/ready word stream. It parses segment headers, generates word-aligned byte addresses and write strobes per target, and frames the whole load with Memory_Initialization. It sits between a host/loader source (bench or UART deframer) and top_risc_v, replacing hand-driven init loops.

## Interface
- IM_DEPTH, 64, instruction memory depth in 32-bit words
- RF_DEPTH, 32, register file depth in words
- SM_DEPTH, 32, system memory depth in words
- clk_100MHz  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; returns block to IDLE
- start  in  1  begin a load session (sampled in IDLE only)
- in_valid / in_data  in  1 / 32  stream word offered
- in_ready  out  1  stream word accepted when in_valid & in_ready
- writeAddr_IM / writeData_IM / writeEn_IM  out  clog2(IM_DEPTH*4) / 32 / 1
- writeAddr_RF_TB / writeData_RF_TB / writeEn_RF_TB  out  clog2(RF_DEPTH*4) / 32 / 1
- writeAddr_SM_TB / writeData_SM_TB / writeEn_SM_TB  out  clog2(SM_DEPTH*4) / 32 / 1
- Memory_Initialization  out  1  high for the whole session
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at session end
- error  out  1  sticky segment-range error; cleared on next accepted start

## Operation
- Header word: [31:30] target (00 IM, 01 RF, 10 SM, 11 END); [29:16] start word index S; [15:0] word count N.
- States: IDLE -> HDR on start; HDR -> DATA on valid non-END header with N>0; HDR stays HDR on N==0; HDR -> FIN on END header; DATA -> HDR after N-th data word accepted; FIN -> IDLE unconditionally (one cycle).
- in_ready = 1 in HDR and DATA, 0 in IDLE and FIN.
- Data word k (k=0..N-1) written to selected target at byte address (S+k)<<2, truncated to port width; only the selected target's writeEn pulses.
- Range check at header acceptance, 17-bit arithmetic: S+N > DEPTH of target -> error set, segment still enters DATA, all N words consumed and discarded (no writeEn), framing preserved.
- Memory_Initialization: 1 from cycle after start accepted through FIN; 0 in IDLE.
- done pulses in the FIN cycle; error remains until next start accepted.
- start while busy: ignored. Header target bits irrelevant in DATA (all words treated as data).
- Unselected ports: addr/data/en hold 0.

## Timing
- Reset values: all writeAddr/writeData/writeEn = 0, in_ready = 0, Memory_Initialization = 0, busy = 0, done = 0, error = 0, state IDLE.
- start sampled at edge T -> HDR, in_ready and Memory_Initialization high from T+1.
- Data word accepted at edge T -> writeEn/addr/data registered, valid during cycle T+1, single-cycle strobe (0 next cycle unless another word accepted).
- Throughput 1 word/cycle; back-to-back segments: header accepted the cycle after last data word, no bubble.
- END accepted at edge T -> FIN during T+1 (last data write also completes by T+1 at latest), IDLE and Memory_Initialization = 0 at T+2.
- in_valid low: no state change, no writes; counters hold.
- Reset mid-session: next cycle all outputs at reset values, in-flight strobe dropped, counters cleared; no done pulse.

## Test plan
- Load IM: start, header 0x0000_0003, words 0x00500093, 0x00A00113, 0x002081B3, header 0xC000_0000 -> writeEn_IM at addr 0x00/0x04/0x08 with those data, done pulse once, Memory_Initialization falls 2 cycles after END.
- Multi-target back-to-back: IM N=2 at S=0, RF header 0x4005_0001 data 0xDEADBEEF, SM header 0x8000_0001 data 0x12345678 -> RF write addr 0x14, SM addr 0x00, no idle cycles between segments, no cross-target strobes.
- Range error: RF header 0x401F_0002 (S=31,N=2) with 2 data words -> error=1, no writeEn_RF_TB, next header parsed correctly, error cleared by next start.
- Stall/backpressure: in_valid toggled 1,0,0,1 during IM segment N=2 -> exactly 2 writes, addresses 0x00 then 0x04, no duplicates.
- Zero-count and ignored start: header 0x0000_0000 then END -> no writes, done pulse; start pulsed while busy -> no effect.
- Reset mid-DATA after first of 3 words -> all outputs 0 next cycle, busy 0, no done; fresh session then loads normally.
